// File: rtl/lane_compositor_pkg.sv
// Shared types and colour constants for the lane compositor.
// Everything here is used by both the pixel pipeline and the flash FSM.
package lane_compositor_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_t;

    localparam rgb_t FROG_COLOR  = rgb_t'(24'h20E020);
    localparam rgb_t BG_COLOR    = rgb_t'(24'h101040);
    localparam rgb_t FLASH_COLOR = rgb_t'(24'hFFFFFF);

    localparam int PALETTE_DEPTH = 4;

    localparam rgb_t LANE_PALETTE [PALETTE_DEPTH] = '{
        rgb_t'(24'hC00000),
        rgb_t'(24'hC0C000),
        rgb_t'(24'h0060C0),
        rgb_t'(24'h8040C0)
    };

endpackage

// File: rtl/box_hit.sv
// Inclusive rectangle test for one pixel, with an optional horizontal wrap
// segment for boxes that run past the right edge of the screen.
module box_hit #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 640,
    parameter bit WRAP_EN  = 1'b1
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    output logic               hit_o
);

    localparam logic [COORD_W:0] SCREEN = (COORD_W+1)'(SCREEN_W);

    logic [COORD_W:0] xEnd;
    logic [COORD_W:0] yEnd;
    logic [COORD_W:0] wrapEnd;
    logic [COORD_W:0] pxExt;
    logic [COORD_W:0] pyExt;
    logic             inX;
    logic             inY;
    logic             inWrap;

    // One extra bit keeps X+W from overflowing before the wrap compare.
    always_comb begin
        xEnd    = {1'b0, x_i} + {1'b0, w_i};
        yEnd    = {1'b0, y_i} + {1'b0, h_i};
        pxExt   = {1'b0, px_i};
        pyExt   = {1'b0, py_i};
        inX     = (px_i >= x_i) && (pxExt <= xEnd);
        inY     = (py_i >= y_i) && (pyExt <= yEnd);
        wrapEnd = '0;
        inWrap  = 1'b0;
        if (WRAP_EN && (xEnd >= SCREEN)) begin
            wrapEnd = xEnd - SCREEN;
            inWrap  = (pxExt <= wrapEnd);
        end
        hit_o = inY && (inX || inWrap);
    end

endmodule

// File: rtl/lane_compositor.sv
// Two-stage pixel compositor: frog over lane objects over background, with a
// frame-counted collision flash that recolours the background.
module lane_compositor
    import lane_compositor_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int OBJS_PER_LANE = 4,
    parameter int COORD_W       = 11,
    parameter int SCREEN_W      = 640,
    parameter int FLASH_FRAMES  = 8
) (
    input  logic                                           Clk,
    input  logic                                           Reset,
    input  logic                                           pix_valid,
    input  logic [COORD_W-1:0]                             DrawX,
    input  logic [COORD_W-1:0]                             DrawY,
    input  logic                                           frame_tick,
    input  logic [COORD_W-1:0]                             FrogX,
    input  logic [COORD_W-1:0]                             FrogY,
    input  logic [COORD_W-1:0]                             Frog_Width,
    input  logic [COORD_W-1:0]                             Frog_Height,
    input  logic [NUM_LANES-1:0][OBJS_PER_LANE-1:0][COORD_W-1:0] Obj_X,
    input  logic [NUM_LANES-1:0][OBJS_PER_LANE-1:0][COORD_W-1:0] Obj_Y,
    input  logic [NUM_LANES-1:0][COORD_W-1:0]              Lane_Width,
    input  logic [NUM_LANES-1:0][COORD_W-1:0]              Lane_Height,
    input  logic [NUM_LANES-1:0][2:0]                      Lane_Count,
    input  logic                                           collision,
    output logic [7:0]                                     Red,
    output logic [7:0]                                     Green,
    output logic [7:0]                                     Blue,
    output logic                                           rgb_valid,
    output logic                                           flashing
);

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_FRAMES - 1);

    logic                                    frogHit;
    logic [NUM_LANES-1:0][OBJS_PER_LANE-1:0] objRaw;
    logic [NUM_LANES-1:0][OBJS_PER_LANE-1:0] objHit;
    logic [NUM_LANES-1:0]                    laneHit;

    logic                 frogHit_q;
    logic [NUM_LANES-1:0] laneHit_q;
    logic                 valid1_q;
    rgb_t                 rgb_d;
    rgb_t                 rgb_q;
    logic                 rgbValid_q;
    flash_state_t         state_q;
    logic [CNT_W-1:0]     flashCnt_q;
    logic                 flashing_q;

    box_hit #(
        .COORD_W (COORD_W),
        .SCREEN_W(SCREEN_W),
        .WRAP_EN (1'b0)
    ) u_frog (
        .x_i  (FrogX),
        .y_i  (FrogY),
        .w_i  (Frog_Width),
        .h_i  (Frog_Height),
        .px_i (DrawX),
        .py_i (DrawY),
        .hit_o(frogHit)
    );

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        for (genvar k = 0; k < OBJS_PER_LANE; k++) begin : g_obj
            box_hit #(
                .COORD_W (COORD_W),
                .SCREEN_W(SCREEN_W),
                .WRAP_EN (1'b1)
            ) u_obj (
                .x_i  (Obj_X[n][k]),
                .y_i  (Obj_Y[n][k]),
                .w_i  (Lane_Width[n]),
                .h_i  (Lane_Height[n]),
                .px_i (DrawX),
                .py_i (DrawY),
                .hit_o(objRaw[n][k])
            );
            // Slots are always below OBJS_PER_LANE, so k < count is the whole test.
            assign objHit[n][k] = objRaw[n][k] && (32'(Lane_Count[n]) > 32'(k));
        end
        assign laneHit[n] = |objHit[n];
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            frogHit_q <= 1'b0;
            laneHit_q <= '0;
            valid1_q  <= 1'b0;
        end else begin
            frogHit_q <= frogHit;
            laneHit_q <= laneHit;
            valid1_q  <= pix_valid;
        end
    end

    // Lanes are scanned high to low so that lane 0 ends up on top.
    always_comb begin
        rgb_d = (state_q == FLASH_ON) ? FLASH_COLOR : BG_COLOR;
        for (int n = NUM_LANES - 1; n >= 0; n--) begin
            if (laneHit_q[n]) begin
                rgb_d = LANE_PALETTE[n % PALETTE_DEPTH];
            end
        end
        if (frogHit_q) begin
            rgb_d = FROG_COLOR;
        end
        if (!valid1_q) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rgb_q      <= '0;
            rgbValid_q <= 1'b0;
        end else begin
            rgb_q      <= rgb_d;
            rgbValid_q <= valid1_q;
        end
    end

    // A collision always wins over a frame tick landing in the same cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            flashCnt_q <= '0;
            flashing_q <= 1'b0;
        end else if (collision) begin
            state_q    <= FLASH_ON;
            flashCnt_q <= CNT_MAX;
            flashing_q <= 1'b1;
        end else if (frame_tick && (state_q != IDLE)) begin
            if (flashCnt_q == '0) begin
                state_q    <= IDLE;
                flashing_q <= 1'b0;
            end else begin
                flashCnt_q <= flashCnt_q - 1'b1;
                state_q    <= (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                flashing_q <= 1'b1;
            end
        end
    end

    assign Red       = rgb_q.r;
    assign Green     = rgb_q.g;
    assign Blue      = rgb_q.b;
    assign rgb_valid = rgbValid_q;
    assign flashing  = flashing_q;

endmodule

// File: tb/tb_lane_compositor.sv
// Randomised scoreboard bench for lane_compositor: a stimulus process queues
// expected pixels from a behavioural scene model and a monitor checks them.
module tb_lane_compositor
    import lane_compositor_pkg::*;
;

    localparam int NL = 4;
    localparam int NO = 4;
    localparam int CW = 11;
    localparam int SW = 640;
    localparam int FF = 8;

    logic                          Clk = 1'b0;
    logic                          Reset;
    logic                          pix_valid;
    logic [CW-1:0]                 DrawX, DrawY;
    logic                          frame_tick;
    logic [CW-1:0]                 FrogX, FrogY, Frog_Width, Frog_Height;
    logic [NL-1:0][NO-1:0][CW-1:0] Obj_X, Obj_Y;
    logic [NL-1:0][CW-1:0]         Lane_Width, Lane_Height;
    logic [NL-1:0][2:0]            Lane_Count;
    logic                          collision;
    logic [7:0]                    Red, Green, Blue;
    logic                          rgb_valid;
    logic                          flashing;

    typedef struct {
        logic [23:0] rgb;
        int          issue;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   monEn  = 1'b0;
    int   mState = 0;
    int   mCnt   = 0;

    lane_compositor #(
        .NUM_LANES    (NL),
        .OBJS_PER_LANE(NO),
        .COORD_W      (CW),
        .SCREEN_W     (SW),
        .FLASH_FRAMES (FF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .pix_valid  (pix_valid),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frame_tick (frame_tick),
        .FrogX      (FrogX),
        .FrogY      (FrogY),
        .Frog_Width (Frog_Width),
        .Frog_Height(Frog_Height),
        .Obj_X      (Obj_X),
        .Obj_Y      (Obj_Y),
        .Lane_Width (Lane_Width),
        .Lane_Height(Lane_Height),
        .Lane_Count (Lane_Count),
        .collision  (collision),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .rgb_valid  (rgb_valid),
        .flashing   (flashing)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cycle <= cycle + 1;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
        end
    endtask

    // Scene model: plain integer geometry, no width tricks needed.
    function automatic bit covers(input int x, input int y, input int w, input int h,
                                  input int px, input int py, input bit wrap);
        bit inX, inY;
        inY = (py >= y) && (py <= y + h);
        inX = (px >= x) && (px <= x + w);
        if (wrap && (x + w >= SW)) inX = inX || (px <= x + w - SW);
        return inX && inY;
    endfunction

    function automatic logic [23:0] refColor(input int px, input int py);
        int lim;
        if (covers(int'(FrogX), int'(FrogY), int'(Frog_Width), int'(Frog_Height), px, py, 1'b0))
            return FROG_COLOR;
        for (int n = 0; n < NL; n++) begin
            lim = (int'(Lane_Count[n]) < NO) ? int'(Lane_Count[n]) : NO;
            for (int k = 0; k < lim; k++) begin
                if (covers(int'(Obj_X[n][k]), int'(Obj_Y[n][k]), int'(Lane_Width[n]),
                           int'(Lane_Height[n]), px, py, 1'b1))
                    return LANE_PALETTE[n % PALETTE_DEPTH];
            end
        end
        return (mState == 1) ? FLASH_COLOR : BG_COLOR;
    endfunction

    // mState: 0 idle, 1 flash colour shown, 2 flash colour hidden.
    function automatic void modelUpdate(input bit coll, input bit tick);
        if (coll) begin
            mState = 1;
            mCnt   = FF - 1;
        end else if (tick && mState != 0) begin
            if (mCnt == 0) mState = 0;
            else begin
                mCnt--;
                mState = (mState == 1) ? 2 : 1;
            end
        end
    endfunction

    task automatic applyStimulus(input bit v, input int px, input int py,
                                 input bit coll = 1'b0, input bit tick = 1'b0);
        pix_valid  = v;
        DrawX      = CW'(px);
        DrawY      = CW'(py);
        collision  = coll;
        frame_tick = tick;
        modelUpdate(coll, tick);
        if (v) sbQ.push_back('{rgb: refColor(px, py), issue: cycle});
        @(posedge Clk);
        #1;
        checkVal("flashing", {31'd0, flashing}, {31'd0, mState != 0});
    endtask

    task automatic resetDut(input int n);
        Reset      = 1'b0;
        pix_valid  = 1'b0;
        collision  = 1'b0;
        frame_tick = 1'b0;
        mState     = 0;
        mCnt       = 0;
        repeat (n) @(posedge Clk);
        #1;
        sbQ.delete();
        checkVal("reset_rgb", {8'd0, Red, Green, Blue}, 32'd0);
        checkVal("reset_valid", {31'd0, rgb_valid}, 32'd0);
        checkVal("reset_flashing", {31'd0, flashing}, 32'd0);
        Reset = 1'b1;
    endtask

    task automatic clearScene();
        FrogX = 11'd1500; FrogY = 11'd1500; Frog_Width = '0; Frog_Height = '0;
        Obj_X = '0; Obj_Y = '0; Lane_Width = '0; Lane_Height = '0; Lane_Count = '0;
    endtask

    task automatic randomScene();
        FrogX       = CW'($urandom_range(0, 639));
        FrogY       = CW'($urandom_range(0, 479));
        Frog_Width  = CW'($urandom_range(0, 40));
        Frog_Height = CW'($urandom_range(0, 40));
        for (int n = 0; n < NL; n++) begin
            Lane_Width[n]  = CW'($urandom_range(0, 120));
            Lane_Height[n] = CW'($urandom_range(0, 60));
            Lane_Count[n]  = 3'($urandom_range(0, 7));
            for (int k = 0; k < NO; k++) begin
                Obj_X[n][k] = CW'($urandom_range(0, 639));
                Obj_Y[n][k] = CW'($urandom_range(0, 479));
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (monEn) begin
                if (rgb_valid) begin
                    checkVal("queue_nonempty", {31'd0, sbQ.size() > 0}, 32'd1);
                    if (sbQ.size() > 0) begin
                        e = sbQ.pop_front();
                        checkVal("pixel_rgb", {8'd0, Red, Green, Blue}, {8'd0, e.rgb});
                        checkVal("pixel_latency", 32'(cycle - e.issue), 32'd2);
                    end
                end else begin
                    checkVal("idle_rgb_zero", {8'd0, Red, Green, Blue}, 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int px, py, n, k;
        DrawX = '0; DrawY = '0;
        clearScene();
        resetDut(3);
        monEn = 1'b1;

        // Basic inclusive edges on lane 0.
        Lane_Count[0] = 3'd1; Obj_X[0][0] = 11'd100; Obj_Y[0][0] = 11'd200;
        Lane_Width[0] = 11'd80; Lane_Height[0] = 11'd40;
        applyStimulus(1, 180, 240);
        applyStimulus(1, 181, 240);
        applyStimulus(1, 100, 200);
        applyStimulus(1, 99, 200);

        // Wrap-around segment.
        Obj_X[0][0] = 11'd600;
        applyStimulus(1, 20, 220);
        applyStimulus(1, 21, 220);
        applyStimulus(1, 639, 220);
        applyStimulus(0, 0, 0);

        // Frog over lane 2, then frog moved away.
        clearScene();
        Lane_Count[2] = 3'd1; Obj_X[2][0] = 11'd280; Obj_Y[2][0] = 11'd280;
        Lane_Width[2] = 11'd40; Lane_Height[2] = 11'd40;
        FrogX = 11'd290; FrogY = 11'd290; Frog_Width = 11'd20; Frog_Height = 11'd20;
        applyStimulus(1, 300, 300);
        FrogX = 11'd10; FrogY = 11'd10;
        applyStimulus(1, 300, 300);

        // Count limits on lane 1.
        clearScene();
        Lane_Width[1] = 11'd10; Lane_Height[1] = 11'd10;
        for (int s = 0; s < NO; s++) begin
            Obj_X[1][s] = CW'(50 + 100 * s);
            Obj_Y[1][s] = 11'd400;
        end
        applyStimulus(1, 55, 405);
        Lane_Count[1] = 3'd7;
        for (int s = 0; s < NO; s++) applyStimulus(1, 55 + 100 * s, 405);
        Lane_Count[1] = 3'd2;
        applyStimulus(1, 255, 405);
        applyStimulus(1, 155, 405);

        // Full flash, then a restart at the fifth tick.
        clearScene();
        applyStimulus(1, 10, 10, 1'b1);
        for (int f = 0; f < FF; f++) begin
            applyStimulus(1, 10, 10);
            applyStimulus(1, 11, 10, 1'b0, 1'b1);
        end
        applyStimulus(1, 12, 10);
        checkVal("flash_idle_after_8", {31'd0, flashing}, 32'd0);
        applyStimulus(1, 10, 10, 1'b1);
        for (int f = 1; f <= 5; f++) applyStimulus(1, 10, 10, f == 5, 1'b1);
        for (int f = 0; f < FF - 1; f++) applyStimulus(1, 10, 10, 1'b0, 1'b1);
        checkVal("restart_still_flashing", {31'd0, flashing}, 32'd1);
        applyStimulus(1, 10, 10, 1'b0, 1'b1);
        checkVal("restart_idle", {31'd0, flashing}, 32'd0);

        // Reset during FLASH_ON with pixels in flight.
        applyStimulus(1, 10, 10, 1'b1);
        applyStimulus(1, 10, 10);
        applyStimulus(1, 10, 10);
        resetDut(1);
        applyStimulus(1, 10, 10);
        applyStimulus(1, 11, 10);

        // Randomised scenes and control traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) randomScene();
            if ($urandom_range(0, 1) == 0) begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end else begin
                n  = $urandom_range(0, NL - 1);
                k  = $urandom_range(0, NO - 1);
                px = (int'(Obj_X[n][k]) + $urandom_range(0, int'(Lane_Width[n]) + 2) + SW - 1) % SW;
                py = (int'(Obj_Y[n][k]) + $urandom_range(0, int'(Lane_Height[n]) + 2) + 479) % 480;
            end
            applyStimulus($urandom_range(0, 3) != 0, px, py,
                          $urandom_range(0, 40) == 0, $urandom_range(0, 8) == 0);
        end

        repeat (4) applyStimulus(0, 0, 0);
        checkVal("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
